// File: rtl/ahbl_cmd_master_pkg.sv
// ahbl_cmd_master_pkg: AHB-Lite encodings and master FSM states shared by the ahbl_cmd_master slice
package ahbl_cmd_master_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA = 4'b0011;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DPH = 2'd1, ST_ERR = 2'd2} state_t;
endpackage

// File: rtl/ahbl_cmd_master_if.sv
// ahbl_cmd_master_if: command, response and AHB-Lite master signals; master = bridge view, slave = caller/bus view
interface ahbl_cmd_master_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [W_ADDR-1:0] cmd_addr;
  logic [1:0] cmd_size;
  logic [W_DATA-1:0] cmd_wdata;
  logic rsp_valid, rsp_err;
  logic [W_DATA-1:0] rsp_rdata;
  logic ahblm_hready, ahblm_hresp, ahblm_hwrite, ahblm_hmastlock;
  logic [W_ADDR-1:0] ahblm_haddr;
  logic [1:0] ahblm_htrans;
  logic [2:0] ahblm_hsize, ahblm_hburst;
  logic [3:0] ahblm_hprot;
  logic [W_DATA-1:0] ahblm_hwdata, ahblm_hrdata;
  modport master (
    input cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input ahblm_hready, ahblm_hresp, ahblm_hrdata,
    output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
    output ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output ahblm_hready, ahblm_hresp, ahblm_hrdata,
    input ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
    input ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );
endinterface

// File: rtl/ahbl_lane_steer.sv
// ahbl_lane_steer: replicates sub-word write data across lanes and right-justifies sub-word read data
// Ports: wr_size/wr_data_i -> wr_data_o (write replicate); rd_size/rd_lane/rd_data_i -> rd_data_o (read extract, zero-extended)
module ahbl_lane_steer
  import ahbl_cmd_master_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data_i,
  output logic [31:0] wr_data_o,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_lane,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);
  logic [31:0] shifted;
  always_comb begin
    wr_data_o = (wr_size == HSIZE_BYTE[1:0]) ? {4{wr_data_i[7:0]}}
              : (wr_size == HSIZE_HALF[1:0]) ? {2{wr_data_i[15:0]}} : wr_data_i;
    shifted = rd_data_i >> {rd_lane, 3'b000};
    rd_data_o = (rd_size == HSIZE_BYTE[1:0]) ? {24'd0, shifted[7:0]}
              : (rd_size == HSIZE_HALF[1:0]) ? {16'd0, shifted[15:0]} : rd_data_i;
  end
endmodule

// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: valid/ready command to AHB-Lite master bridge, pipelined one transfer per cycle
// Ports: clk, rst (sync, active-high); bus (ahbl_cmd_master_if.master: cmd_*, rsp_*, ahblm_*)
// Build option: AHBL_CMD_MASTER_LANE_STEER_EN enables byte/halfword lane steering
module ahbl_cmd_master
  import ahbl_cmd_master_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input logic clk,
  input logic rst,
  ahbl_cmd_master_if.master bus
);
  state_t state_q, state_d;
  logic wr_q, wr_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0] size_q, size_d, lane_q, lane_d;
  logic [W_DATA-1:0] wdata_q, wdata_d, wdata_in, rd_data, rsp_rdata_q, rsp_rdata_d;
  logic in_err, accept, done;
  assign in_err = state_q == ST_ERR;
  assign bus.cmd_ready = bus.ahblm_hready && !in_err;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign done = state_q != ST_IDLE && bus.ahblm_hready;
  // the pending address phase is withdrawn as soon as an ERROR response starts, not only in its second cycle
  assign bus.ahblm_htrans = (bus.cmd_valid && !in_err && !(bus.ahblm_hresp && !bus.ahblm_hready) && !rst)
                          ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.ahblm_haddr = W_ADDR'(bus.cmd_addr);
  assign bus.ahblm_hwrite = bus.cmd_write;
  assign bus.ahblm_hsize = {1'b0, bus.cmd_size};
  assign bus.ahblm_hburst = HBURST_SINGLE;
  assign bus.ahblm_hprot = HPROT_DATA;
  assign bus.ahblm_hmastlock = 1'b0;
  assign bus.ahblm_hwdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef AHBL_CMD_MASTER_LANE_STEER_EN
  ahbl_lane_steer u_steer (
    .wr_size(bus.cmd_size),
    .wr_data_i(bus.cmd_wdata),
    .wr_data_o(wdata_in),
    .rd_size(size_q),
    .rd_lane(lane_q),
    .rd_data_i(bus.ahblm_hrdata),
    .rd_data_o(rd_data)
  );
`else
  logic unused_dph;
  assign wdata_in = bus.cmd_wdata;
  assign rd_data = bus.ahblm_hrdata;
  assign unused_dph = ^{size_q, lane_q};
`endif
  always_comb begin
    state_d = in_err ? (bus.ahblm_hready ? ST_IDLE : ST_ERR)
            : (state_q == ST_DPH && !bus.ahblm_hready) ? (bus.ahblm_hresp ? ST_ERR : ST_DPH)
            : accept ? ST_DPH : ST_IDLE;
    wr_d = accept ? bus.cmd_write : wr_q;
    size_d = accept ? bus.cmd_size : size_q;
    lane_d = accept ? bus.cmd_addr[1:0] : lane_q;
    wdata_d = accept ? wdata_in : wdata_q;
    rsp_valid_d = done;
    rsp_err_d = done && (in_err || bus.ahblm_hresp);
    rsp_rdata_d = (done && !rsp_err_d && !wr_q) ? rd_data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q <= 1'b0;
      size_q <= '0;
      lane_q <= '0;
      wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      size_q <= size_d;
      lane_q <= lane_d;
      wdata_q <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_ahbl_cmd_master.sv
// tb_ahbl_cmd_master: directed + random stimulus against a byte-memory response model and an AHB-Lite slave with wait/error knobs
module tb_ahbl_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ahbl_cmd_master_if bus ();
  ahbl_cmd_master dut (.clk(clk), .rst(rst), .bus(bus));
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // slave: word memory, zero-wait by default, optional wait states and two-cycle ERROR
  logic [31:0] mem [0:255];
  logic dp_v = 1'b0;
  logic dp_w, dp_e, dp_e2;
  logic [31:0] dp_a;
  logic [2:0] dp_s;
  int dp_wait;
  logic wait_en = 1'b0, err_en = 1'b0, rand_wait = 1'b0;
  logic [31:0] wait_addr = 32'h20, err_addr = 32'h40;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [1:0] lane, input logic [2:0] sz);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++)
      if (i >= int'(lane) && i < int'(lane) + (1 << sz)) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction
  assign bus.ahblm_hready = !dp_v || (dp_e ? dp_e2 : dp_wait == 0);
  assign bus.ahblm_hresp = dp_v && dp_e;
  assign bus.ahblm_hrdata = (dp_v && !dp_w) ? mem[dp_a[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      dp_v <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.ahblm_hready) begin
      if (dp_v && dp_w && !dp_e) mem[dp_a[9:2]] <= merge(mem[dp_a[9:2]], bus.ahblm_hwdata, dp_a[1:0], dp_s);
      dp_v <= bus.ahblm_htrans == 2'b10;
      dp_a <= bus.ahblm_haddr;
      dp_w <= bus.ahblm_hwrite;
      dp_s <= bus.ahblm_hsize;
      dp_e <= err_en && bus.ahblm_haddr == err_addr;
      dp_e2 <= 1'b0;
      dp_wait <= (wait_en && bus.ahblm_haddr == wait_addr) ? 2 : rand_wait ? int'($urandom_range(0, 2)) : 0;
    end else if (dp_e) dp_e2 <= 1'b1;
    else dp_wait <= dp_wait - 1;
  end
  // reference model: byte-addressed memory, one expected {err, rdata} per accepted command, in order
  logic [7:0] ref_b [0:1023];
  logic [32:0] exp_q [$];
  logic [32:0] e;
  logic [31:0] v, last_rdata;
  logic last_err;
  int a, n, rsp_cnt = 0, err_cnt = 0, run = 0, run_max = 0, last_rsp_cyc = 0;
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      err_cnt += int'(bus.rsp_err);
      last_rsp_cyc = cyc;
      last_rdata = bus.rsp_rdata;
      last_err = bus.rsp_err;
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e[31:0]);
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[32]});
      end
    end
    run = (bus.rsp_valid === 1'b1) ? run + 1 : 0;
    if (run > run_max) run_max = run;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
    end else if (bus.cmd_valid && bus.cmd_ready) begin
      a = int'(bus.cmd_addr[9:0]);
      n = 1 << bus.cmd_size;
      if (err_en && bus.cmd_addr == err_addr) exp_q.push_back({1'b1, 32'h0});
      else if (bus.cmd_write) begin
        for (int i = 0; i < n; i++)
`ifdef AHBL_CMD_MASTER_LANE_STEER_EN
          ref_b[a + i] = bus.cmd_wdata[8*i +: 8];
`else
          ref_b[a + i] = bus.cmd_wdata[8*((a % 4) + i) +: 8];
`endif
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        v = 32'h0;
`ifdef AHBL_CMD_MASTER_LANE_STEER_EN
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[a + i];
`else
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_b[(a & ~3) + i];
`endif
        exp_q.push_back({1'b0, v});
      end
    end
  end
  int tries, pcyc, stalls, c0;
  task automatic send(input logic [31:0] ad, input logic w, input logic [1:0] s, input logic [31:0] d);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = ad;
    bus.cmd_write = w;
    bus.cmd_size = s;
    bus.cmd_wdata = d;
    tries = 0;
    while (!ok && tries < 64) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      pcyc = cyc;
      tries++;
      @(posedge clk);
      #1;
    end
    check("send_accept", {31'd0, ok}, 32'd1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic idle(input int k);
    bus.cmd_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h0;
    bus.cmd_write = 1'b0;
    bus.cmd_size = 2'd2;
    bus.cmd_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_htrans", {30'd0, bus.ahblm_htrans}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("hburst", {29'd0, bus.ahblm_hburst}, 32'd0);
    check("hprot", {28'd0, bus.ahblm_hprot}, 32'd3);
    check("hmastlock", {31'd0, bus.ahblm_hmastlock}, 32'd0);
    step();
    rst = 1'b0;
    idle(2);
    c0 = rsp_cnt;
    send(32'h10, 1'b1, 2'd2, 32'hDEADBEEF);
    idle(3);
    check("lat_write", last_rsp_cyc - pcyc, 32'd2);
    send(32'h10, 1'b0, 2'd2, 32'h0);
    idle(3);
    check("lat_read", last_rsp_cyc - pcyc, 32'd2);
    check("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    check("rd_err", {31'd0, last_err}, 32'd0);
    check("wr_rd_pulses", rsp_cnt - c0, 32'd2);
    c0 = rsp_cnt;
    run_max = 0;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      send(32'(i * 4), 1'b1, 2'd2, $urandom);
      stalls += (tries != 1) ? 1 : 0;
    end
    idle(4);
    check("b2b_stalls", stalls, 32'd0);
    check("b2b_run", run_max, 32'd256);
    check("b2b_pulses", rsp_cnt - c0, 32'd256);
    for (int i = 0; i < 32; i++) send(32'($urandom_range(0, 255) * 4), 1'b0, 2'd2, 32'h0);
    idle(4);
    wait_en = 1'b1;
    c0 = rsp_cnt;
    send(32'h20, 1'b0, 2'd2, 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h24;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ws_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check("ws_haddr", bus.ahblm_haddr, 32'h24);
      check("ws_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      step();
    end
    send(32'h24, 1'b1, 2'd2, 32'h12345678);
    check("ws_accept_tries", tries, 32'd1);
    idle(3);
    wait_en = 1'b0;
    check("ws_pulses", rsp_cnt - c0, 32'd2);
    err_en = 1'b1;
    c0 = err_cnt;
    send(32'h40, 1'b1, 2'd2, 32'hCAFEF00D);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h44;
    bus.cmd_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("err_htrans", {30'd0, bus.ahblm_htrans}, 32'd0);
      check("err_ready", {31'd0, bus.cmd_ready}, 32'd0);
      step();
    end
    send(32'h44, 1'b0, 2'd2, 32'h0);
    check("err_reissue_tries", tries, 32'd1);
    idle(3);
    err_en = 1'b0;
    check("err_pulses", err_cnt - c0, 32'd1);
    send(32'h40, 1'b0, 2'd2, 32'h0);
    idle(3);
    check("after_err_rd", {31'd0, last_err}, 32'd0);
`ifdef AHBL_CMD_MASTER_LANE_STEER_EN
    send(32'h13, 1'b1, 2'd0, 32'h000000A5);
    @(negedge clk);
    check("steer_hwdata_b", bus.ahblm_hwdata, 32'hA5A5A5A5);
    step();
    send(32'h13, 1'b0, 2'd0, 32'h0);
    idle(3);
    check("steer_rdata_b", last_rdata, 32'h000000A5);
    send(32'h22, 1'b1, 2'd1, 32'h0000BEEF);
    @(negedge clk);
    check("steer_hwdata_h", bus.ahblm_hwdata, 32'hBEEFBEEF);
    step();
    send(32'h22, 1'b0, 2'd1, 32'h0);
    idle(3);
    check("steer_rdata_h", last_rdata, 32'h0000BEEF);
`endif
    rand_wait = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(32'($urandom_range(0, 255) * 4), 1'($urandom), 2'd2, $urandom);
    end
    idle(6);
    rand_wait = 1'b0;
    check("sb_drained", exp_q.size(), 32'd0);
    c0 = rsp_cnt;
    send(32'h30, 1'b1, 2'd2, 32'h55AA55AA);
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h34;
    @(negedge clk);
    check("rst_mid_htrans", {30'd0, bus.ahblm_htrans}, 32'd0);
    step();
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    idle(3);
    check("rst_mid_nopulse", rsp_cnt - c0, 32'd0);
    send(32'h8, 1'b1, 2'd2, 32'h0BADF00D);
    send(32'h8, 1'b0, 2'd2, 32'h0);
    idle(3);
    check("post_rst_rd", last_rdata, 32'h0BADF00D);
    check("sb_final", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
